// File: rtl/elixirchip_es1_spu_op_sub_seq.sv
// Multi-word subtract sequencer: issues WORDS slices LSW-first to an external spu_op_sub, chaining carries.
// Result after WORDS*(LATENCY+1) cke cycles; one transaction in flight, s_ready low until the result is taken.
module elixirchip_es1_spu_op_sub_seq #(
    parameter int LATENCY        = 1,
    parameter int DATA_BITS      = 8,
    parameter int WORDS          = 4,
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cke,
    input  logic [WORDS*DATA_BITS-1:0] s_data0,
    input  logic [WORDS*DATA_BITS-1:0] s_data1,
    input  logic                       s_carry,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WORDS*DATA_BITS-1:0] m_data,
    output logic                       m_carry,
    output logic                       m_overflow,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       op_carry,
    output logic [DATA_BITS-1:0]       op_data0,
    output logic [DATA_BITS-1:0]       op_data1,
    output logic                       op_clear,
    output logic                       op_valid,
    input  logic [DATA_BITS-1:0]       op_m_data,
    input  logic                       op_m_msb_c,
    input  logic                       op_m_carry
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                              state_q, state_d;
    logic [WORDS-1:0][DATA_BITS-1:0]     a_q, a_d;
    logic [WORDS-1:0][DATA_BITS-1:0]     b_q, b_d;
    logic [WORDS-1:0][DATA_BITS-1:0]     m_data_q, m_data_d;
    logic                                carry_q, carry_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                m_carry_q, m_carry_d;
    logic                                m_overflow_q, m_overflow_d;
    logic                                capture;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        m_data_d     = m_data_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        m_carry_d    = m_carry_q;
        m_overflow_d = m_overflow_q;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        op_valid     = 1'b0;
        capture      = 1'b0;

        case (state_q)
            ST_CLEAR: state_d = ST_IDLE;
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    a_d     = s_data0;
                    b_d     = s_data1;
                    carry_d = s_carry;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                op_valid = 1'b1;
                cnt_d    = CNT_LOAD;
                if (LATENCY == 0) begin
                    capture = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                end
            end
            ST_DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        // The returned carry is registered, so the next word issues a cycle later at the earliest.
        if (capture) begin
            m_data_d[idx_q] = op_m_data;
            carry_d         = op_m_carry;
            if (idx_q == LAST_IDX) begin
                m_carry_d    = op_m_carry;
                m_overflow_d = op_m_msb_c ^ op_m_carry;
                state_d      = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            a_q          <= '0;
            b_q          <= '0;
            m_data_q     <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            m_carry_q    <= 1'b0;
            m_overflow_q <= 1'b0;
        end else if (cke) begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            m_data_q     <= m_data_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            m_carry_q    <= m_carry_d;
            m_overflow_q <= m_overflow_d;
        end
    end

    assign op_data0   = a_q[idx_q];
    assign op_data1   = b_q[idx_q];
    assign op_carry   = carry_q;
    assign op_clear   = CLEAR_ON_START && reset_n && (state_q == ST_CLEAR);
    assign m_data     = m_data_q;
    assign m_carry    = m_carry_q;
    assign m_overflow = m_overflow_q;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sub_seq.sv
// Bench for the subtract sequencer: three instances (LATENCY 0, 1, 3) share stimulus, each with its own op model.
module tb_elixirchip_es1_spu_op_sub_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cke;
    logic [31:0] s_data0;
    logic [31:0] s_data1;
    logic        s_carry;
    logic        s_valid;
    logic        m_ready;

    logic        s_ready_w   [3];
    logic [31:0] m_data_w    [3];
    logic        m_carry_w   [3];
    logic        m_ov_w      [3];
    logic        m_valid_w   [3];
    logic        op_carry_w  [3];
    logic [7:0]  op_d0_w     [3];
    logic [7:0]  op_d1_w     [3];
    logic        op_clear_w  [3];
    logic        op_valid_w  [3];
    logic [7:0]  op_md_w     [3];
    logic        op_msbc_w   [3];
    logic        op_mc_w     [3];

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int e0     = 0;
    int done_at [3];
    bit timed_out;
    int lat_of [3] = '{0, 1, 3};

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // Behaviour of the attached 8-bit spu_op_sub: A + ~B + carry, returning {msb_c, carry, data}.
    function automatic logic [9:0] op_model(input logic [7:0] d0, input logic [7:0] d1, input logic c);
        logic [8:0] full;
        logic [7:0] low;
        full = {1'b0, d0} + {1'b0, ~d1} + {8'd0, c};
        low  = {1'b0, d0[6:0]} + {1'b0, ~d1[6:0]} + {7'd0, c};
        return {low[7], full[8], full[7:0]};
    endfunction

    // Whole-operand reference: difference with borrow-in, no-borrow flag and signed overflow.
    function automatic void exp_sub(input logic [31:0] a, input logic [31:0] b, input logic c,
                                    output logic [31:0] d, output logic co, output logic ov);
        longint unsigned la, lb;
        la = 64'(a);
        lb = 64'(b) + (c ? 64'd0 : 64'd1);
        d  = a - b - (c ? 32'd0 : 32'd1);
        co = (la >= lb);
        ov = (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [9:0] res;

        elixirchip_es1_spu_op_sub_seq #(
            .LATENCY(L), .DATA_BITS(8), .WORDS(4), .CLEAR_ON_START(1'b1)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .cke(cke),
            .s_data0(s_data0), .s_data1(s_data1), .s_carry(s_carry),
            .s_valid(s_valid), .s_ready(s_ready_w[g]),
            .m_data(m_data_w[g]), .m_carry(m_carry_w[g]), .m_overflow(m_ov_w[g]),
            .m_valid(m_valid_w[g]), .m_ready(m_ready),
            .op_carry(op_carry_w[g]), .op_data0(op_d0_w[g]), .op_data1(op_d1_w[g]),
            .op_clear(op_clear_w[g]), .op_valid(op_valid_w[g]),
            .op_m_data(op_md_w[g]), .op_m_msb_c(op_msbc_w[g]), .op_m_carry(op_mc_w[g])
        );

        if (L == 0) begin : g_comb
            assign res = op_model(op_d0_w[g], op_d1_w[g], op_carry_w[g]);
        end else begin : g_pipe
            logic [9:0] pipe [L];
            always @(posedge clk) begin
                if (cke) begin
                    pipe[0] <= op_model(op_d0_w[g], op_d1_w[g], op_carry_w[g]);
                    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign res = pipe[L-1];
        end

        assign op_md_w[g]   = res[7:0];
        assign op_mc_w[g]   = res[8];
        assign op_msbc_w[g] = res[9];
    end

    task automatic apply_ops(input logic [31:0] a, input logic [31:0] b, input logic c);
        s_data0 = a;
        s_data1 = b;
        s_carry = c;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        e0      = edges;
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < 3; i++) done_at[i] = -1;
        for (int k = 0; k < 300; k++) begin
            all_done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (m_valid_w[i] && done_at[i] < 0) done_at[i] = edges - e0;
                if (done_at[i] < 0) all_done = 1'b0;
            end
            if (all_done) break;
            @(posedge clk);
            #1;
        end
        timed_out = !all_done;
    endtask

    task automatic release_result();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_ready_w[i], m_valid_w[i], op_valid_w[i], op_clear_w[i]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: got rdy/vld/opv/clr=%b%b%b%b expected 0000", i,
                         s_ready_w[i], m_valid_w[i], op_valid_w[i], op_clear_w[i]);
            end
            checks++;
            if ({m_data_w[i], m_carry_w[i], m_ov_w[i]} !== 34'd0) begin
                errors++;
                $display("FAIL reset_data inst%0d: got %h/%b/%b expected 0", i, m_data_w[i], m_carry_w[i], m_ov_w[i]);
            end
        end
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (op_clear_w[i] !== 1'b1 || s_ready_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL clear_cycle inst%0d: got clr=%b rdy=%b expected clr=1 rdy=0", i, op_clear_w[i], s_ready_w[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (op_clear_w[i] !== 1'b0 || s_ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_clear inst%0d: got clr=%b rdy=%b expected clr=0 rdy=1", i, op_clear_w[i], s_ready_w[i]);
            end
        end
    endtask

    task automatic test_vectors(input int n_random);
        logic [31:0] va [4] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] vb [4] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        logic [31:0] a, b, ed;
        logic c, ec, eo;
        for (int t = 0; t < 4 + n_random; t++) begin
            if (t < 4) begin
                a = va[t];
                b = vb[t];
                c = 1'b1;
            end else begin
                a = $urandom;
                b = $urandom;
                c = 1'($urandom_range(0, 1));
            end
            exp_sub(a, b, c, ed, ec, eo);
            apply_ops(a, b, c);
            wait_done();
            checks++;
            if (timed_out !== 1'b0) begin
                errors++;
                $display("FAIL vec_timeout t%0d: no m_valid within budget", t);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (m_data_w[i] !== ed || m_carry_w[i] !== ec || m_ov_w[i] !== eo) begin
                    errors++;
                    $display("FAIL vec_result t%0d inst%0d (%h-%h c=%b): got %h/%b/%b expected %h/%b/%b",
                             t, i, a, b, c, m_data_w[i], m_carry_w[i], m_ov_w[i], ed, ec, eo);
                end
                checks++;
                if (done_at[i] != 4 * (lat_of[i] + 1)) begin
                    errors++;
                    $display("FAIL vec_latency t%0d inst%0d: got %0d expected %0d", t, i, done_at[i], 4 * (lat_of[i] + 1));
                end
            end
            release_result();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (m_valid_w[i] !== 1'b0 || s_ready_w[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL vec_handshake t%0d inst%0d: got vld=%b rdy=%b expected 0/1", t, i, m_valid_w[i], s_ready_w[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, ed1, ed2;
        logic ec1, eo1, ec2, eo2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        exp_sub(a1, b1, 1'b1, ed1, ec1, eo1);
        exp_sub(a2, b2, 1'b1, ed2, ec2, eo2);
        apply_ops(a1, b1, 1'b1);
        wait_done();
        s_data0 = a2;
        s_data1 = b2;
        s_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (s_ready_w[i] !== 1'b0 || m_valid_w[i] !== 1'b1 || m_data_w[i] !== ed1) begin
                    errors++;
                    $display("FAIL hold_done inst%0d: got rdy=%b vld=%b data=%h expected 0/1/%h",
                             i, s_ready_w[i], m_valid_w[i], m_data_w[i], ed1);
                end
            end
        end
        release_result();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_ready_w[i] !== 1'b1 || m_valid_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_release inst%0d: got rdy=%b vld=%b expected 1/0", i, s_ready_w[i], m_valid_w[i]);
            end
        end
        apply_ops(a2, b2, 1'b1);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_data_w[i] !== ed2 || m_carry_w[i] !== ec2 || m_ov_w[i] !== eo2) begin
                errors++;
                $display("FAIL second_op inst%0d: got %h/%b/%b expected %h/%b/%b",
                         i, m_data_w[i], m_carry_w[i], m_ov_w[i], ed2, ec2, eo2);
            end
        end
        release_result();
    endtask

    task automatic test_cke();
        logic [31:0] a, b, ed;
        logic ec, eo;
        logic [16:0] low;
        a = $urandom; b = $urandom;
        exp_sub(a, b, 1'b1, ed, ec, eo);
        low = {1'b0, a[15:0]} + {1'b0, ~b[15:0]} + 17'd1;
        apply_ops(a, b, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        cke = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (op_d0_w[1] !== a[23:16] || op_d1_w[1] !== b[23:16] || op_carry_w[1] !== low[16] || op_valid_w[1] !== 1'b0) begin
                errors++;
                $display("FAIL cke_freeze_op: got d0=%h d1=%h c=%b v=%b expected %h/%h/%b/0",
                         op_d0_w[1], op_d1_w[1], op_carry_w[1], op_valid_w[1], a[23:16], b[23:16], low[16]);
            end
        end
        cke = 1'b1;
        wait_done();
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (done_at[i] != 4 * (lat_of[i] + 1) + 3) begin
                errors++;
                $display("FAIL cke_latency inst%0d: got %0d expected %0d", i, done_at[i], 4 * (lat_of[i] + 1) + 3);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_data_w[i] !== ed || m_carry_w[i] !== ec || m_ov_w[i] !== eo) begin
                errors++;
                $display("FAIL cke_result inst%0d: got %h/%b/%b expected %h/%b/%b",
                         i, m_data_w[i], m_carry_w[i], m_ov_w[i], ed, ec, eo);
            end
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        apply_ops($urandom, $urandom, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_ready_w[i], m_valid_w[i], op_valid_w[i], op_clear_w[i]} !== 4'b0000 || m_data_w[i] !== 32'd0) begin
                errors++;
                $display("FAIL mid_reset inst%0d: got rdy/vld/opv/clr=%b%b%b%b data=%h expected 0000/0", i,
                         s_ready_w[i], m_valid_w[i], op_valid_w[i], op_clear_w[i], m_data_w[i]);
            end
        end
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (op_clear_w[i] !== 1'b1 || s_ready_w[i] !== 1'b0 || m_valid_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_clear inst%0d: got clr=%b rdy=%b vld=%b expected 1/0/0", i, op_clear_w[i], s_ready_w[i], m_valid_w[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (s_ready_w[i] !== 1'b1 || op_clear_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_idle inst%0d: got rdy=%b clr=%b expected 1/0", i, s_ready_w[i], op_clear_w[i]);
            end
        end
        apply_ops(32'h0000_0010, 32'h0000_0001, 1'b1);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_data_w[i] !== 32'h0000_000F || m_carry_w[i] !== 1'b1 || timed_out !== 1'b0) begin
                errors++;
                $display("FAIL fresh_after_reset inst%0d: got %h/%b expected 0000000f/1", i, m_data_w[i], m_carry_w[i]);
            end
        end
        release_result();
    endtask

    initial begin
        reset_n = 1'b0;
        cke     = 1'b1;
        s_data0 = '0;
        s_data1 = '0;
        s_carry = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_vectors(16);
        test_back_to_back();
        test_cke();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elixirchip_es1_spu_op_sub_seq.md
Name: elixirchip_es1_spu_op_sub_seq

Overview:
Multi-word subtract sequencer. It is the initiator side of the spu_op_sub operand interface.
- Accepts wide operands A and B through a valid/ready handshake.
- Slices them into DATA_BITS words, LSW first, and drives them one per issue into an external spu_op_sub instance.
- Feeds each returned carry back as the next word's carry.
- Reassembles the WORDS-word difference and presents it with final carry and signed-overflow flags on a valid/ready output.

Parameters:
- LATENCY, 1: latency of the attached spu_op_sub, in cke-qualified cycles; 0 allowed.
- DATA_BITS, 8: word width of the attached op.
- WORDS, 4: number of words per operand; must be ≥1.
- CLEAR_ON_START, 1'b1: pulse op_clear during the CLEAR state after reset.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- cke  in  1  clock enable; all state holds when 0
- s_data0  in  WORDS*DATA_BITS  minuend A
- s_data1  in  WORDS*DATA_BITS  subtrahend B
- s_carry  in  1  initial carry; 1 = no borrow-in
- s_valid  in  1  operand valid
- s_ready  out  1  operand accept
- m_data  out  WORDS*DATA_BITS  A - B (mod 2^(WORDS*DATA_BITS))
- m_carry  out  1  final carry; 1 = no borrow
- m_overflow  out  1  signed overflow = msb_c XOR carry of the top word
- m_valid  out  1  result valid
- m_ready  in  1  result accept
- op_carry  out  1  to op s_carry
- op_data0  out  DATA_BITS  to op s_data0
- op_data1  out  DATA_BITS  to op s_data1
- op_clear  out  1  to op s_clear
- op_valid  out  1  to op s_valid
- op_m_data  in  DATA_BITS  from op m_data
- op_m_msb_c  in  1  from op m_msb_c
- op_m_carry  in  1  from op m_carry

Behaviour:
- Clocking and reset:
  - All registers update on posedge clk only when cke=1. Latency counts are in cke=1 cycles.
  - reset_n=0 overrides cke. State goes to CLEAR, and s_ready, m_valid, op_valid, op_clear = 0.
  - m_data, m_carry and m_overflow reset to 0.
- States: CLEAR, IDLE, ISSUE, WAIT, DONE.
- CLEAR:
  - Lasts one cycle after reset_n rises.
  - op_clear = CLEAR_ON_START; op_valid = 0. Then go to IDLE.
- IDLE:
  - s_ready = 1.
  - When s_valid & s_ready: latch A, B and s_carry into carry_r. Set idx = 0 and go to ISSUE.
- ISSUE (one cycle):
  - op_valid = 1.
  - op_data0 = A[idx], op_data1 = B[idx], op_carry = carry_r.
  - Load wait counter with LATENCY.
  - If LATENCY = 0, capture in this same cycle; otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle. op_valid = 0; op_data and op_carry hold.
  - Capture when the counter reaches 1, i.e. in cycle issue+LATENCY.
- Capture:
  - result[idx] = op_m_data; carry_r = op_m_carry.
  - If idx = WORDS-1: m_carry = op_m_carry, m_overflow = op_m_msb_c ^ op_m_carry, go to DONE.
  - Otherwise idx+1, go to ISSUE.
- Timing:
  - Each word takes LATENCY+1 cycles.
  - m_valid rises WORDS*(LATENCY+1) cycles after the accept edge.
  - Carry is never forwarded combinationally into the next issue.
- DONE:
  - m_valid = 1. m_data, m_carry and m_overflow are stable while m_ready = 0.
  - On m_ready: m_valid = 0 and go to IDLE.
  - No new accept is allowed in the handshake cycle; s_ready rises the following cycle.
- Outside CLEAR, op_clear = 0. op_valid = 1 only in ISSUE.
- s_ready = 0 in every state except IDLE. No overlap of transactions.
- reset_n low mid-operation:
  - Aborts the transaction; no partial result is emitted.
  - The CLEAR cycle re-clears the op; then IDLE.
- WORDS = 1 is the degenerate single-issue case and must work.
- idx counter width is clog2(WORDS), minimum 1.

Test Plan:
Default configuration unless stated: WORDS=4, DATA_BITS=8, LATENCY=1, s_carry=1.
1. A=0x00000005, B=0x00000003 -> m_data=0x00000002, m_carry=1, m_overflow=0; m_valid exactly 8 cycles after the accept edge.
2. A=0x00000000, B=0x00000001 -> m_data=0xFFFFFFFF, m_carry=0, m_overflow=0 (borrow ripples through all 4 words).
3. A=0x80000000, B=0x00000001 -> m_data=0x7FFFFFFF, m_carry=1, m_overflow=1. Repeat with LATENCY=0 and LATENCY=3: same result, m_valid at 4 and 16 cycles.
4. Hold m_ready=0 for 5 cycles in DONE while s_valid=1 with new operands -> m_data stable, s_ready=0, no accept. After the m_ready handshake, s_ready=1 next cycle and the second operation completes correctly.
5. Drop cke for 3 cycles during WAIT of word 2 -> op outputs and internal state frozen; m_valid delayed exactly 3 cycles; result unchanged.
6. Assert reset_n=0 during ISSUE of word 1 -> s_ready, m_valid and op_valid = 0. After release: one cycle with op_clear=1, then s_ready=1; a fresh 0x00000010-0x00000001 yields 0x0000000F.
